// File: rtl/rv_dec_pkg.sv
// Shared RV32I decode definitions: alu_info_bus layout, op-bit indices and opcode/funct constants.
// Used by idu_dec_stage and the EXU ALU decoder so both ends agree on the bus encoding.
package rv_dec_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INFO_W = 14;

    typedef enum logic [2:0] {
        TYPE_NONE = 3'b000,
        TYPE_ALU  = 3'b001,
        TYPE_BJP  = 3'b010,
        TYPE_AGU  = 3'b011,
        TYPE_CSR  = 3'b100
    } info_type_e;

    localparam logic [3:0] ALU_ADD  = 4'd0,  ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4,  ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR   = 4'd8,  ALU_AND = 4'd9, ALU_IMM = 4'd10;

    localparam logic [3:0] BJP_JAL  = 4'd0, BJP_BEQ  = 4'd1, BJP_BNE = 4'd2, BJP_BLT   = 4'd3,
                           BJP_BGE  = 4'd4, BJP_BLTU = 4'd5, BJP_BGEU = 4'd6, BJP_LUI  = 4'd7,
                           BJP_AUIPC = 4'd8, BJP_JALR = 4'd9;

    localparam logic [3:0] AGU_LB = 4'd0, AGU_LH = 4'd1, AGU_LW = 4'd2, AGU_LBU = 4'd3,
                           AGU_LHU = 4'd4, AGU_SB = 4'd5, AGU_SH = 4'd6, AGU_SW = 4'd7;

    localparam logic [3:0] CSR_FENCE  = 4'd0, CSR_FENCEI = 4'd1, CSR_ECALL  = 4'd2,
                           CSR_EBREAK = 4'd3, CSR_RW     = 4'd4, CSR_RS     = 4'd5,
                           CSR_RC     = 4'd6, CSR_RWI    = 4'd7, CSR_RSI    = 4'd8,
                           CSR_RCI    = 4'd9;

    localparam logic [6:0] OPC_LUI    = 7'b0110111, OPC_AUIPC  = 7'b0010111,
                           OPC_JAL    = 7'b1101111, OPC_JALR   = 7'b1100111,
                           OPC_BRANCH = 7'b1100011, OPC_LOAD   = 7'b0000011,
                           OPC_STORE  = 7'b0100011, OPC_OP_IMM = 7'b0010011,
                           OPC_OP     = 7'b0110011, OPC_MISC   = 7'b0001111,
                           OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_SH, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z
    } imm_sel_e;

    // Registered decode payload handed across the ID/EX boundary (immediate and PC kept separately).
    typedef struct packed {
        logic [INFO_W-1:0] info;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              wen;
        logic [11:0]       csr_addr;
    } dec_t;

    function automatic logic [INFO_W-1:0] mk_info(input info_type_e t, input logic [3:0] b);
        logic [INFO_W-1:0] r;
        r        = '0;
        r[13:11] = t;
        r[b]     = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/idu_dec_stage_if.sv
// IFU->IDU fetch handshake and IDU->EXU decoded-instruction bus.
// master = decode stage, slave = the IFU/EXU side driving it.
interface idu_dec_stage_if;
    import rv_dec_pkg::*;

    logic              ifu_valid;
    logic              ifu_ready;
    logic [XLEN-1:0]   ifu_instr;
    logic [XLEN-1:0]   ifu_pc;
    logic              exu_valid;
    logic              exu_ready;
    logic [INFO_W-1:0] alu_info_bus;
    logic [4:0]        rs1_idx;
    logic [4:0]        rs2_idx;
    logic [4:0]        rd_idx;
    logic              rd_wen;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [11:0]       csr_addr;

    modport master (
        input  ifu_valid, ifu_instr, ifu_pc, exu_ready,
        output ifu_ready, exu_valid, alu_info_bus, rs1_idx, rs2_idx, rd_idx, rd_wen, imm, pc, csr_addr
    );

    modport slave (
        output ifu_valid, ifu_instr, ifu_pc, exu_ready,
        input  ifu_ready, exu_valid, alu_info_bus, rs1_idx, rs2_idx, rd_idx, rd_wen, imm, pc, csr_addr
    );

endinterface

// File: rtl/idu_imm_gen.sv
// Immediate generator: picks the I/S/B/U/J/shamt/zimm form of the instruction word.
module idu_imm_gen
    import rv_dec_pkg::*;
(
    input  logic [31:7]     i_instr,
    input  imm_sel_e        i_sel,
    output logic [XLEN-1:0] o_imm
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        o_imm = '0;
        case (i_sel)
            IMM_I:  o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_SH: o_imm = {27'b0, i_instr[24:20]};
            IMM_S:  o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:  o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                             i_instr[11:8], 1'b0};
            IMM_U:  o_imm = {i_instr[31:12], 12'b0};
            IMM_J:  o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                             i_instr[30:21], 1'b0};
            IMM_Z:  o_imm = {27'b0, i_instr[19:15]};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/idu_dec_stage.sv
// RV32I decode stage with registered ID/EX boundary; stalls after ecall/ebreak/fence.i until EXU retires it.
// Define IDU_ILLEGAL_TRAP_EN to add o_illegal and serialize on illegal encodings.
module idu_dec_stage
    import rv_dec_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_flush,
    input  logic i_serial_done,
`ifdef IDU_ILLEGAL_TRAP_EN
    output logic o_illegal,
`endif
    idu_dec_stage_if.master io_bus
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]      r_state;
    logic            r_exu_valid;
    dec_t            r_dec;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc;

    dec_t            w_dec;
    imm_sel_e        w_imm_sel;
    logic [XLEN-1:0] w_imm;
    info_type_e      w_type;
    logic [3:0]      w_bit;
    logic            w_imm_flag;
    logic            w_wen_raw;
    logic            w_is_serial;
    logic            w_illegal;
    logic            w_serial;
    logic            w_ifu_ready;
    logic            w_capture;

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    assign w_opc = io_bus.ifu_instr[6:0];
    assign w_f3  = io_bus.ifu_instr[14:12];
    assign w_f7  = io_bus.ifu_instr[31:25];

    always_comb begin
        w_dec       = '0;
        w_imm_sel   = IMM_NONE;
        w_type      = TYPE_NONE;
        w_bit       = '0;
        w_imm_flag  = 1'b0;
        w_wen_raw   = 1'b0;
        w_is_serial = 1'b0;
        w_illegal   = 1'b0;
        case (w_opc)
            OPC_LUI, OPC_AUIPC: begin
                w_type = TYPE_BJP;  w_bit = (w_opc == OPC_LUI) ? BJP_LUI : BJP_AUIPC;
                w_dec.rd = io_bus.ifu_instr[11:7];  w_wen_raw = 1'b1;  w_imm_sel = IMM_U;
            end
            OPC_JAL: begin
                w_type = TYPE_BJP;  w_bit = BJP_JAL;
                w_dec.rd = io_bus.ifu_instr[11:7];  w_wen_raw = 1'b1;  w_imm_sel = IMM_J;
            end
            OPC_JALR: begin
                w_type = TYPE_BJP;  w_bit = BJP_JALR;  w_illegal = (w_f3 != 3'b000);
                w_dec.rs1 = io_bus.ifu_instr[19:15];  w_dec.rd = io_bus.ifu_instr[11:7];
                w_wen_raw = 1'b1;  w_imm_sel = IMM_I;
            end
            OPC_BRANCH: begin
                w_type = TYPE_BJP;  w_imm_sel = IMM_B;
                w_dec.rs1 = io_bus.ifu_instr[19:15];  w_dec.rs2 = io_bus.ifu_instr[24:20];
                case (w_f3)
                    3'b000: w_bit = BJP_BEQ;   3'b001: w_bit = BJP_BNE;
                    3'b100: w_bit = BJP_BLT;   3'b101: w_bit = BJP_BGE;
                    3'b110: w_bit = BJP_BLTU;  3'b111: w_bit = BJP_BGEU;
                    default: w_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                w_type = TYPE_AGU;  w_imm_sel = IMM_I;  w_wen_raw = 1'b1;
                w_dec.rs1 = io_bus.ifu_instr[19:15];  w_dec.rd = io_bus.ifu_instr[11:7];
                case (w_f3)
                    3'b000: w_bit = AGU_LB;   3'b001: w_bit = AGU_LH;  3'b010: w_bit = AGU_LW;
                    3'b100: w_bit = AGU_LBU;  3'b101: w_bit = AGU_LHU;
                    default: w_illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                w_type = TYPE_AGU;  w_imm_sel = IMM_S;
                w_dec.rs1 = io_bus.ifu_instr[19:15];  w_dec.rs2 = io_bus.ifu_instr[24:20];
                case (w_f3)
                    3'b000: w_bit = AGU_SB;  3'b001: w_bit = AGU_SH;  3'b010: w_bit = AGU_SW;
                    default: w_illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                w_type = TYPE_ALU;  w_imm_flag = 1'b1;  w_wen_raw = 1'b1;  w_imm_sel = IMM_I;
                w_dec.rs1 = io_bus.ifu_instr[19:15];  w_dec.rd = io_bus.ifu_instr[11:7];
                case (w_f3)
                    3'b000: w_bit = ALU_ADD;   3'b010: w_bit = ALU_SLT;
                    3'b011: w_bit = ALU_SLTU;  3'b100: w_bit = ALU_XOR;
                    3'b110: w_bit = ALU_OR;    3'b111: w_bit = ALU_AND;
                    3'b001: begin
                        w_bit = ALU_SLL;  w_imm_sel = IMM_SH;  w_illegal = (w_f7 != F7_BASE);
                    end
                    default: begin
                        w_imm_sel = IMM_SH;
                        if (w_f7 == F7_BASE)     w_bit = ALU_SRL;
                        else if (w_f7 == F7_ALT) w_bit = ALU_SRA;
                        else                     w_illegal = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                w_type = TYPE_ALU;  w_wen_raw = 1'b1;
                w_dec.rs1 = io_bus.ifu_instr[19:15];  w_dec.rs2 = io_bus.ifu_instr[24:20];
                w_dec.rd  = io_bus.ifu_instr[11:7];
                if (w_f7 == F7_BASE) begin
                    case (w_f3)
                        3'b000: w_bit = ALU_ADD;   3'b001: w_bit = ALU_SLL;
                        3'b010: w_bit = ALU_SLT;   3'b011: w_bit = ALU_SLTU;
                        3'b100: w_bit = ALU_XOR;   3'b101: w_bit = ALU_SRL;
                        3'b110: w_bit = ALU_OR;    default: w_bit = ALU_AND;
                    endcase
                end else if (w_f7 == F7_ALT && w_f3 == 3'b000) begin
                    w_bit = ALU_SUB;
                end else if (w_f7 == F7_ALT && w_f3 == 3'b101) begin
                    w_bit = ALU_SRA;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OPC_MISC: begin
                w_type = TYPE_CSR;
                case (w_f3)
                    3'b000: w_bit = CSR_FENCE;
                    3'b001: begin w_bit = CSR_FENCEI;  w_is_serial = 1'b1; end
                    default: w_illegal = 1'b1;
                endcase
            end
            OPC_SYSTEM: begin
                w_type = TYPE_CSR;
                w_dec.rd = io_bus.ifu_instr[11:7];  w_wen_raw = 1'b1;
                w_dec.csr_addr = io_bus.ifu_instr[31:20];
                case (w_f3)
                    3'b001: begin w_bit = CSR_RW;  w_dec.rs1 = io_bus.ifu_instr[19:15]; end
                    3'b010: begin w_bit = CSR_RS;  w_dec.rs1 = io_bus.ifu_instr[19:15]; end
                    3'b011: begin w_bit = CSR_RC;  w_dec.rs1 = io_bus.ifu_instr[19:15]; end
                    3'b101: begin w_bit = CSR_RWI; w_imm_sel = IMM_Z; end
                    3'b110: begin w_bit = CSR_RSI; w_imm_sel = IMM_Z; end
                    3'b111: begin w_bit = CSR_RCI; w_imm_sel = IMM_Z; end
                    3'b000: begin
                        // ecall/ebreak carry no register or CSR operands.
                        w_dec.rd = '0;  w_wen_raw = 1'b0;  w_dec.csr_addr = '0;
                        w_is_serial = 1'b1;
                        if (io_bus.ifu_instr[31:7] == 25'h0)              w_bit = CSR_ECALL;
                        else if (io_bus.ifu_instr[31:7] == {12'h001, 13'h0}) w_bit = CSR_EBREAK;
                        else                                                  w_illegal = 1'b1;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase

        w_dec.info = mk_info(w_type, w_bit);
        if (w_imm_flag) w_dec.info[ALU_IMM] = 1'b1;
        w_dec.wen = w_wen_raw & (w_dec.rd != 5'd0);

        if (w_illegal) begin
            w_dec       = '0;
            w_imm_sel   = IMM_NONE;
            w_is_serial = 1'b0;
        end
    end

    idu_imm_gen u_imm_gen (
        .i_instr (io_bus.ifu_instr[31:7]),
        .i_sel   (w_imm_sel),
        .o_imm   (w_imm)
    );

`ifdef IDU_ILLEGAL_TRAP_EN
    assign w_serial = w_is_serial | w_illegal;
`else
    assign w_serial = w_is_serial;
`endif

    assign w_ifu_ready = i_flush | ((r_state == ST_RUN) & (~r_exu_valid | io_bus.exu_ready));
    assign w_capture   = io_bus.ifu_valid & w_ifu_ready & ~i_flush;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_exu_valid <= 1'b0;
            r_dec       <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
        end else if (i_flush) begin
            r_state     <= ST_RUN;
            r_exu_valid <= 1'b0;
        end else begin
            if (w_capture) begin
                r_exu_valid <= 1'b1;
                r_dec       <= w_dec;
                r_imm       <= w_imm;
                r_pc        <= io_bus.ifu_pc;
            end else if (io_bus.exu_ready) begin
                r_exu_valid <= 1'b0;
            end
            if (w_capture && w_serial)                r_state <= ST_WAIT;
            else if (r_state == ST_WAIT && i_serial_done) r_state <= ST_RUN;
        end
    end

`ifdef IDU_ILLEGAL_TRAP_EN
    logic r_illegal;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     r_illegal <= 1'b0;
        else if (!i_flush && w_capture) r_illegal <= w_illegal;
    end
    assign o_illegal = r_illegal;
`endif

    assign io_bus.ifu_ready    = w_ifu_ready;
    assign io_bus.exu_valid    = r_exu_valid;
    assign io_bus.alu_info_bus = r_dec.info;
    assign io_bus.rs1_idx      = r_dec.rs1;
    assign io_bus.rs2_idx      = r_dec.rs2;
    assign io_bus.rd_idx       = r_dec.rd;
    assign io_bus.rd_wen       = r_dec.wen;
    assign io_bus.imm          = r_imm;
    assign io_bus.pc           = r_pc;
    assign io_bus.csr_addr     = r_dec.csr_addr;

endmodule

// File: tb/tb_idu_dec_stage.sv
// Directed bench for idu_dec_stage: table of decode vectors at full throughput, then stall,
// serialization, flush and reset sequences.
module tb_idu_dec_stage;

    logic clk;
    logic rst_n;
    logic i_flush;
    logic i_serial_done;
    int   n_checks;
    int   n_errors;

    idu_dec_stage_if bus ();

    idu_dec_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_flush       (i_flush),
        .i_serial_done (i_serial_done),
        .io_bus        (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [13:0] info;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wen;
        logic [11:0] csr;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        bus.ifu_valid = 1'b1;
        bus.ifu_instr = instr;
        bus.ifu_pc    = pc;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        //          instr          info      imm            rs1 rs2 rd  wen csr
        vecs[0]  = '{32'hFFD08293, 14'h0C01, 32'hFFFFFFFD, 1, 0, 5,  1, 12'h000}; // addi x5,x1,-3
        vecs[1]  = '{32'h00208463, 14'h1002, 32'h00000008, 1, 2, 0,  0, 12'h000}; // beq x1,x2,+8
        vecs[2]  = '{32'h123450B7, 14'h1080, 32'h12345000, 0, 0, 1,  1, 12'h000}; // lui x1
        vecs[3]  = '{32'h402081B3, 14'h0802, 32'h00000000, 1, 2, 3,  1, 12'h000}; // sub x3,x1,x2
        vecs[4]  = '{32'h40535393, 14'h0C80, 32'h00000005, 6, 0, 7,  1, 12'h000}; // srai x7,x6,5
        vecs[5]  = '{32'hFFC12403, 14'h1804, 32'hFFFFFFFC, 2, 0, 8,  1, 12'h000}; // lw x8,-4(x2)
        vecs[6]  = '{32'h00912623, 14'h1880, 32'h0000000C, 2, 9, 0,  0, 12'h000}; // sw x9,12(x2)
        vecs[7]  = '{32'hFF9FF0EF, 14'h1001, 32'hFFFFFFF8, 0, 0, 1,  1, 12'h000}; // jal x1,-8
        vecs[8]  = '{32'h00208033, 14'h0801, 32'h00000000, 1, 2, 0,  0, 12'h000}; // add x0,x1,x2
        vecs[9]  = '{32'h3002E573, 14'h2100, 32'h00000005, 0, 0, 10, 1, 12'h300}; // csrrsi x10,0x300,5
        vecs[10] = '{32'h00001117, 14'h1100, 32'h00001000, 0, 0, 2,  1, 12'h000}; // auipc x2,1
        vecs[11] = '{32'h00008067, 14'h1200, 32'h00000000, 1, 0, 0,  0, 12'h000}; // jalr x0,0(x1)
        vecs[12] = '{32'h00000000, 14'h0000, 32'h00000000, 0, 0, 0,  0, 12'h000}; // unsupported -> NOP

        rst_n = 1'b0;  i_flush = 1'b0;  i_serial_done = 1'b0;
        bus.ifu_valid = 1'b0;  bus.ifu_instr = '0;  bus.ifu_pc = '0;  bus.exu_ready = 1'b1;
        #12;
        check("rst_exu_valid", 64'(bus.exu_valid), 64'd0);
        check("rst_info",      64'(bus.alu_info_bus), 64'd0);
        check("rst_payload",   {bus.imm, bus.pc}, 64'd0);
        check("rst_idx_wen",   64'({bus.rs1_idx, bus.rs2_idx, bus.rd_idx, bus.rd_wen, bus.csr_addr}), 64'd0);
        check("rst_ifu_ready", 64'(bus.ifu_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // Full-throughput table: a new instruction every cycle with EXU always ready.
        for (int i = 0; i < 13; i++) begin
            send(vecs[i].instr, 32'h1000 + 32'(i * 4));
            #1;
            check($sformatf("v%0d_ifu_ready", i), 64'(bus.ifu_ready), 64'd1);
            tick();
            check($sformatf("v%0d_valid", i), 64'(bus.exu_valid), 64'd1);
            check($sformatf("v%0d_info", i),  64'(bus.alu_info_bus), 64'(vecs[i].info));
            check($sformatf("v%0d_imm", i),   64'(bus.imm), 64'(vecs[i].imm));
            check($sformatf("v%0d_regs", i),  64'({bus.rs1_idx, bus.rs2_idx, bus.rd_idx, bus.rd_wen}),
                  64'({vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].wen}));
            check($sformatf("v%0d_csr", i),   64'(bus.csr_addr), 64'(vecs[i].csr));
            check($sformatf("v%0d_pc", i),    64'(bus.pc), 64'(32'h1000 + 32'(i * 4)));
        end
        bus.ifu_valid = 1'b0;
        tick();
        check("drain_valid", 64'(bus.exu_valid), 64'd0);

        // EXU backpressure: second instruction held off, first frozen, both delivered in order.
        bus.exu_ready = 1'b0;
        send(32'hFFD08293, 32'h2000);
        tick();
        send(32'h123450B7, 32'h2004);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stall%0d_ifu_ready", c), 64'(bus.ifu_ready), 64'd0);
            check($sformatf("stall%0d_frozen", c), {18'(bus.exu_valid), 14'(bus.alu_info_bus), bus.pc},
                  {18'd1, 14'h0C01, 32'h2000});
            tick();
        end
        bus.exu_ready = 1'b1;
        #1;
        check("unstall_ifu_ready", 64'(bus.ifu_ready), 64'd1);
        tick();
        bus.ifu_valid = 1'b0;
        check("unstall_second", {18'(bus.exu_valid), 14'(bus.alu_info_bus), bus.pc},
              {18'd1, 14'h1080, 32'h2004});
        tick();
        check("unstall_drain", 64'(bus.exu_valid), 64'd0);

        // ecall serializes until i_serial_done.
        send(32'h00000073, 32'h3000);
        tick();
        check("ecall_info", {18'(bus.exu_valid), 14'(bus.alu_info_bus), 32'(bus.rd_wen)},
              {18'd1, 14'h2004, 32'd0});
        send(32'hFFD08293, 32'h3004);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("wait%0d_ifu_ready", c), 64'(bus.ifu_ready), 64'd0);
            tick();
        end
        check("wait_exu_consumed", 64'(bus.exu_valid), 64'd0);
        i_serial_done = 1'b1;
        tick();
        i_serial_done = 1'b0;
        #1;
        check("done_ifu_ready", 64'(bus.ifu_ready), 64'd1);
        tick();
        bus.ifu_valid = 1'b0;
        check("after_ecall", {18'(bus.exu_valid), 14'(bus.alu_info_bus), bus.pc},
              {18'd1, 14'h0C01, 32'h3004});
        // i_serial_done while running must not disturb the handshake.
        i_serial_done = 1'b1;
        tick();
        i_serial_done = 1'b0;
        check("done_in_run", {32'(bus.ifu_ready), 32'(bus.exu_valid)}, {32'd1, 32'd0});

        // Flush while EXU stalls: pending input accepted and discarded.
        bus.exu_ready = 1'b0;
        send(32'hFFD08293, 32'h4000);
        tick();
        send(32'h123450B7, 32'h4004);
        i_flush = 1'b1;
        #1;
        check("flush_ifu_ready", 64'(bus.ifu_ready), 64'd1);
        tick();
        i_flush = 1'b0;
        bus.ifu_valid = 1'b0;
        check("flush_stall_valid", 64'(bus.exu_valid), 64'd0);
        tick();
        check("flush_discard", 64'(bus.exu_valid), 64'd0);
        bus.exu_ready = 1'b1;

        // Flush in WAIT returns the FSM to RUN.
        send(32'h00100073, 32'h5000);
        tick();
        bus.ifu_valid = 1'b0;
        check("ebreak_info", {32'(bus.exu_valid), 32'(bus.alu_info_bus)}, {32'd1, 32'h2008});
        #1;
        check("ebreak_wait", 64'(bus.ifu_ready), 64'd0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        #1;
        check("flush_wait", {32'(bus.exu_valid), 32'(bus.ifu_ready)}, {32'd0, 32'd1});
        send(32'h402081B3, 32'h5004);
        tick();
        bus.ifu_valid = 1'b0;
        check("post_flush_cap", {18'(bus.exu_valid), 14'(bus.alu_info_bus), bus.pc},
              {18'd1, 14'h0802, 32'h5004});

        // Reset mid-stream clears everything immediately, even from WAIT.
        send(32'h00000073, 32'h6000);
        tick();
        bus.ifu_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {32'(bus.exu_valid), 32'(bus.alu_info_bus)}, 64'd0);
        check("rst_mid_pc",    64'(bus.pc), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_mid_run", 64'(bus.ifu_ready), 64'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
